ram_fifo_ctrl: RTL and testbench

RAM_FIFO_CTRL -- requirements
Module: ram_fifo_ctrl

---
 rtl/ram_fifo_ctrl.sv | 101 ++++++++++
 tb/tb_ram_fifo_ctrl.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/ram_fifo_ctrl.sv
// FIFO controller around an external dual-port RAM with registered read data.
// A two-entry output buffer absorbs the RAM read latency so reads can stream at one word per cycle.
module ram_fifo_ctrl #(
   parameter int ADDR_WDT = 10,
   parameter int DATA_WDT = 8
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                s_valid,
   output logic                s_ready,
   input  logic [DATA_WDT-1:0] s_data,
   output logic                m_valid,
   input  logic                m_ready,
   output logic [DATA_WDT-1:0] m_data,
   output logic                ram_rst,
   output logic [ADDR_WDT-1:0] ram_addra,
   output logic [DATA_WDT-1:0] ram_dina,
   output logic                ram_wea,
   output logic [ADDR_WDT-1:0] ram_addrb,
   output logic [DATA_WDT-1:0] ram_dinb,
   output logic                ram_web,
   input  logic [DATA_WDT-1:0] ram_doutb,
   output logic [ADDR_WDT+1:0] count,
   output logic                empty,
   output logic                full
);

   localparam int DEPTH = 2**ADDR_WDT;
   localparam logic [ADDR_WDT:0] DEPTH_CNT = (ADDR_WDT+1)'(DEPTH);

   logic [ADDR_WDT-1:0] wr_ptr;
   logic [ADDR_WDT-1:0] rd_ptr;
   logic [ADDR_WDT:0]   ram_cnt;
   logic                inflight;
   logic [1:0]          out_cnt;
   logic [DATA_WDT-1:0] buf_head;
   logic [DATA_WDT-1:0] buf_tail;

   logic       push;
   logic       pop;
   logic       rd_issue;
   logic       fill_head;
   logic [1:0] occ_after;

   always_comb begin
      s_ready   = !rst && (ram_cnt < DEPTH_CNT);
      m_valid   = !rst && (out_cnt != 2'd0);
      push      = s_valid && s_ready;
      pop       = m_valid && m_ready;
      // Buffer occupancy once this cycle's returning word lands and any pop leaves.
      occ_after = out_cnt + {1'b0, inflight} - {1'b0, pop};
      rd_issue  = (ram_cnt != '0) && (occ_after < 2'd2);
      fill_head = (out_cnt == {1'b0, pop});
   end

   assign ram_rst   = rst;
   assign ram_addra = wr_ptr;
   assign ram_dina  = s_data;
   assign ram_wea   = push;
   assign ram_addrb = rd_ptr;
   assign ram_dinb  = '0;
   assign ram_web   = 1'b0;
   assign m_data    = buf_head;
   assign count     = (ADDR_WDT+2)'(ram_cnt) + (ADDR_WDT+2)'(inflight) + (ADDR_WDT+2)'(out_cnt);
   assign empty     = (count == '0);
   assign full      = (ram_cnt == DEPTH_CNT);

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr   <= '0;
         rd_ptr   <= '0;
         ram_cnt  <= '0;
         inflight <= 1'b0;
         out_cnt  <= 2'd0;
         buf_head <= '0;
         buf_tail <= '0;
      end else begin
         if (push)
            wr_ptr <= wr_ptr + ADDR_WDT'(1);
         if (rd_issue)
            rd_ptr <= rd_ptr + ADDR_WDT'(1);
         case ({push, rd_issue})
            2'b10:   ram_cnt <= ram_cnt + (ADDR_WDT+1)'(1);
            2'b01:   ram_cnt <= ram_cnt - (ADDR_WDT+1)'(1);
            default: ram_cnt <= ram_cnt;
         endcase
         inflight <= rd_issue;
         out_cnt  <= occ_after;
         if (pop)
            buf_head <= buf_tail;
         // Returning RAM word goes to the first free slot after the pop shift.
         if (inflight) begin
            if (fill_head)
               buf_head <= ram_doutb;
            else
               buf_tail <= ram_doutb;
         end
      end
   end

endmodule

// File: tb/tb_ram_fifo_ctrl.sv
// Scoreboard bench for ram_fifo_ctrl: a behavioural RAM plus a queue of accepted words
// that an independent monitor compares against every output handshake.
module tb_ram_fifo_ctrl;

   localparam int AW    = 10;
   localparam int DW    = 8;
   localparam int DEPTH = 1 << AW;

   logic          clk = 1'b0;
   logic          rst;
   logic          s_valid;
   logic          s_ready;
   logic [DW-1:0] s_data;
   logic          m_valid;
   logic          m_ready;
   logic [DW-1:0] m_data;
   logic          ram_rst;
   logic [AW-1:0] ram_addra;
   logic [DW-1:0] ram_dina;
   logic          ram_wea;
   logic [AW-1:0] ram_addrb;
   logic [DW-1:0] ram_dinb;
   logic          ram_web;
   logic [DW-1:0] ram_doutb;
   logic [AW+1:0] count;
   logic          empty;
   logic          full;

   ram_fifo_ctrl #(.ADDR_WDT(AW), .DATA_WDT(DW)) dut (
      .clk(clk), .rst(rst),
      .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
      .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data),
      .ram_rst(ram_rst), .ram_addra(ram_addra), .ram_dina(ram_dina), .ram_wea(ram_wea),
      .ram_addrb(ram_addrb), .ram_dinb(ram_dinb), .ram_web(ram_web), .ram_doutb(ram_doutb),
      .count(count), .empty(empty), .full(full)
   );

   always #5 clk = ~clk;

   // Dual-port RAM, registered read output.
   logic [DW-1:0] mem [DEPTH];
   always @(posedge clk) begin
      if (ram_wea) mem[ram_addra] <= ram_dina;
      if (ram_web) mem[ram_addrb] <= ram_dinb;
      ram_doutb <= mem[ram_addrb];
   end

   int            checks = 0;
   int            failures = 0;
   int            cyc = 0;
   int            pop_total = 0;
   int            first_pop_cyc = -1;
   int            last_pop_cyc = -1;
   logic          prev_stall = 1'b0;
   logic [DW-1:0] prev_data = '0;
   logic [DW-1:0] exp_q [$];

   task automatic check(input string name, input longint act, input longint exp);
      checks++;
      if (act != exp) begin
         failures++;
         $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Monitor: samples between edges, so state and inputs are stable for the coming edge.
   always @(negedge clk) begin
      cyc++;
      if (rst) begin
         exp_q.delete();
         prev_stall = 1'b0;
      end else begin
         check("count", count, exp_q.size());
         check("empty", empty, exp_q.size() == 0);
         if (prev_stall && m_valid) check("head_stable", m_data, prev_data);
         if (m_valid && m_ready) begin
            check("pop_nonempty", exp_q.size() != 0, 1);
            if (exp_q.size() != 0) check("m_data", m_data, exp_q.pop_front());
            pop_total++;
            if (first_pop_cyc < 0) first_pop_cyc = cyc;
            last_pop_cyc = cyc;
         end
         if (s_valid && s_ready) exp_q.push_back(s_data);
         prev_stall = m_valid && !m_ready;
         prev_data  = m_data;
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic drain(input int lim);
      int n = 0;
      s_valid = 1'b0;
      m_ready = 1'b1;
      while ((exp_q.size() != 0 || m_valid) && n < lim) begin
         step();
         n++;
      end
      check("drain_done", exp_q.size(), 0);
   endtask

   initial begin
      int acc;
      int n;
      int base;
      rst = 1'b1; s_valid = 1'b0; s_data = '0; m_ready = 1'b0;
      repeat (3) @(posedge clk);
      #1 rst = 1'b0;

      // Reset state
      @(negedge clk);
      check("rst_m_valid", m_valid, 0);
      check("rst_s_ready", s_ready, 1);
      check("rst_full", full, 0);
      check("rst_count", count, 0);
      check("rst_wea", ram_wea, 0);

      // Latency: push in cycle 0, output in cycle 3, count zero in cycle 4
      step(); s_valid = 1'b1; s_data = 8'hA5; m_ready = 1'b1;
      step(); s_valid = 1'b0;
      step();
      @(negedge clk); check("lat_early_valid", m_valid, 0);
      step();
      @(negedge clk); check("lat_valid", m_valid, 1); check("lat_data", m_data, 8'hA5);
      step();
      @(negedge clk); check("lat_count", count, 0);

      // Streaming with wrap-around: 2048 words, one per cycle
      step();
      base = pop_total; first_pop_cyc = -1;
      m_ready = 1'b1; s_valid = 1'b1; acc = 0; n = 0;
      while (acc < 2048 && n < 5000) begin
         s_data = 8'(acc);
         @(negedge clk);
         if (s_ready) acc++;
         step();
         n++;
      end
      check("stream_accepted", acc, 2048);
      check("stream_in_cycles", n, 2048);
      drain(100);
      check("stream_popped", pop_total - base, 2048);
      check("stream_no_gaps", last_pop_cyc - first_pop_cyc, 2047);

      // Fill until backpressure, then single pop
      m_ready = 1'b0; s_valid = 1'b1; acc = 0; n = 0;
      while (n < 3000) begin
         s_data = 8'($urandom);
         @(negedge clk);
         if (!s_ready) break;
         acc++;
         step();
         n++;
      end
      check("fill_accepted", acc, DEPTH + 2);
      check("fill_full", full, 1);
      check("fill_count", count, DEPTH + 2);
      step(); m_ready = 1'b1;
      @(negedge clk); check("fill_pop_cycle_s_ready", s_ready, 0);
      step(); m_ready = 1'b0; s_valid = 1'b0;
      @(negedge clk); check("fill_after_pop_s_ready", s_ready, 1);
      check("fill_after_pop_full", full, 0);
      drain(3000);

      // Backpressure: random 30% m_ready during continuous push
      acc = 0; n = 0;
      while (acc < 600 && n < 5000) begin
         s_valid = 1'b1;
         s_data  = 8'($urandom);
         m_ready = ($urandom_range(0, 99) < 30);
         @(negedge clk);
         if (s_ready) acc++;
         step();
         n++;
      end
      check("bp_accepted", acc, 600);
      drain(3000);

      // Reset mid-operation
      m_ready = 1'b0; s_valid = 1'b1; acc = 0;
      while (acc < 10) begin
         s_data = 8'(acc + 100);
         @(negedge clk);
         if (s_ready) acc++;
         step();
      end
      s_valid = 1'b0;
      @(negedge clk); check("mid_held", count, 10);
      step(); rst = 1'b1; s_valid = 1'b1; s_data = 8'h77;
      @(negedge clk);
      check("mid_rst_wea", ram_wea, 0);
      check("mid_rst_m_valid", m_valid, 0);
      check("mid_ram_rst", ram_rst, 1);
      step(); rst = 1'b0; s_valid = 1'b0;
      @(negedge clk);
      check("mid_count", count, 0);
      check("mid_m_valid", m_valid, 0);
      check("mid_s_ready", s_ready, 1);
      check("mid_ram_rst_low", ram_rst, 0);
      step(); s_valid = 1'b1; s_data = 8'h3C; m_ready = 1'b1;
      step(); s_valid = 1'b0;
      n = 0;
      while (!m_valid && n < 20) begin step(); n++; end
      check("mid_first_valid", m_valid, 1);
      check("mid_first_data", m_data, 8'h3C);
      drain(50);
      check("tie_web", ram_web, 0);
      check("tie_dinb", ram_dinb, 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
